// File: rtl/map_pkg.sv
// Shared tile-map types, level ROM base table and loader state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package map_pkg;

   typedef enum logic [1:0] {
      TILE_BG    = 2'b00,
      TILE_BLOCK = 2'b01,
      TILE_SPIKE = 2'b10,
      TILE_CHECK = 2'b11
   } tile_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_DOWN  = 2'b11
   } spike_dir_t;

   localparam int NUM_CELLS = 300;
   localparam int MAP_COLS  = 20;
   localparam int MAP_ROWS  = 15;

   // First record address of each level; entry 3 is the invalid level.
   localparam logic [9:0] LEVEL_BASE [0:3] = '{10'd0, 10'd256, 10'd512, 10'd768};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LATCH,
      ST_RUN,
      ST_DONE
   } ld_state_t;

   // Direction only means something on a spike; every other tile stores 00.
   function automatic logic [3:0] cell_word(tile_t t, spike_dir_t d);
      return {t, (t == TILE_SPIKE) ? d : DIR_UP};
   endfunction

endpackage

// File: rtl/map_loader_if.sv
// Load request, level ROM, tile RAM write and status bundle of the map loader.
// Latency: n/a (wiring only).
// Backpressure: none; the tile RAM always accepts and the ROM answers next cycle.
interface map_loader_if #(
   parameter int ROM_AW = 10
);
   logic              load_req;
   logic [1:0]        load_level;
   logic [ROM_AW-1:0] rom_addr;
   logic [7:0]        rom_data;
   logic              wr_en;
   logic [8:0]        wr_addr;
   logic [3:0]        wr_data;
   logic              busy;
   logic              done;
   logic              err;

   // Game-state logic / ROM / RAM side.
   modport master (
      output load_req, load_level, rom_data,
      input  rom_addr, wr_en, wr_addr, wr_data, busy, done, err
   );

   // Loader side.
   modport slave (
      input  load_req, load_level, rom_data,
      output rom_addr, wr_en, wr_addr, wr_data, busy, done, err
   );
endinterface

// File: rtl/map_loader.sv
// Decodes RLE level records from the level ROM into one tile RAM write per clock.
// Latency: 2+len cycles per record, first FETCH the cycle after load_req is taken.
// Backpressure: none; load_req is only sampled in IDLE and ignored otherwise.
module map_loader #(
   parameter int ROM_AW    = 10,
   parameter int NUM_CELLS = 300
) (
   input logic         Clk,
   input logic         Reset_n,
   map_loader_if.slave bus
);
   import map_pkg::tile_t;
   import map_pkg::spike_dir_t;
   import map_pkg::ld_state_t;
   import map_pkg::LEVEL_BASE;
   import map_pkg::cell_word;
   import map_pkg::ST_IDLE;
   import map_pkg::ST_FETCH;
   import map_pkg::ST_LATCH;
   import map_pkg::ST_RUN;
   import map_pkg::ST_DONE;
   import map_pkg::TILE_BG;
   import map_pkg::DIR_UP;

   localparam logic [8:0] LAST_CELL = 9'(NUM_CELLS - 1);

   ld_state_t         state;
   logic [8:0]        cell_cnt;
   logic [ROM_AW-1:0] rom_ptr;    // wraps modulo 2^ROM_AW
   tile_t             run_tile;
   spike_dir_t        run_dir;
   logic [3:0]        run_left;   // cells remaining in the run after the current one
   logic              overrun;
   logic              inv_err;    // one-cycle flag for a request of level 11

   // Loader FSM: record fetch, decode and run expansion.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= ST_IDLE;
         cell_cnt <= '0;
         rom_ptr  <= '0;
         run_tile <= TILE_BG;
         run_dir  <= DIR_UP;
         run_left <= '0;
         overrun  <= 1'b0;
         inv_err  <= 1'b0;
      end else begin
         inv_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.load_req) begin
                  if (bus.load_level == 2'b11) begin
                     inv_err <= 1'b1;
                  end else begin
                     state    <= ST_FETCH;
                     rom_ptr  <= ROM_AW'(LEVEL_BASE[bus.load_level]);
                     cell_cnt <= '0;
                     overrun  <= 1'b0;
                  end
               end
            end
            ST_FETCH: begin
               state <= ST_LATCH;
            end
            ST_LATCH: begin
               run_tile <= tile_t'(bus.rom_data[7:6]);
               run_dir  <= spike_dir_t'(bus.rom_data[5:4]);
               run_left <= bus.rom_data[3:0];
               rom_ptr  <= rom_ptr + 1'b1;
               state    <= ST_RUN;
            end
            ST_RUN: begin
               if (cell_cnt == LAST_CELL) begin
                  // Map full: any cells left in this run are dropped.
                  state   <= ST_DONE;
                  overrun <= (run_left != 4'd0);
               end else begin
                  cell_cnt <= cell_cnt + 9'd1;
                  if (run_left == 4'd0) begin
                     state <= ST_FETCH;
                  end else begin
                     run_left <= run_left - 4'd1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs decode from registered state only.
   always_comb begin
      bus.rom_addr = rom_ptr;
      bus.wr_en    = (state == ST_RUN);
      bus.wr_addr  = (state == ST_RUN) ? cell_cnt : 9'd0;
      bus.wr_data  = (state == ST_RUN) ? cell_word(run_tile, run_dir) : 4'd0;
      bus.busy     = (state == ST_FETCH) || (state == ST_LATCH) || (state == ST_RUN);
      bus.done     = (state == ST_DONE);
      bus.err      = inv_err || ((state == ST_DONE) && overrun);
   end

endmodule

// File: tb/tb_map_loader.sv
// Directed bench for map_loader with a synchronous ROM model and write monitor.
// Latency: checks first FETCH, last write and done cycle of a full load.
// Backpressure: exercises ignored requests mid-run and during DONE.
module tb_map_loader;

   logic Clk;
   logic Reset_n;

   map_loader_if #(.ROM_AW(10)) bus();

   map_loader #(.ROM_AW(10), .NUM_CELLS(300)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [7:0] rom [0:1023];
   logic [3:0] mem [0:299];

   // Synchronous level ROM: data valid the cycle after the address.
   always @(posedge Clk) bus.rom_data <= rom[bus.rom_addr];

   int pe_cnt = 0;
   always @(posedge Clk) pe_cnt <= pe_cnt + 1;

   int n_cmp = 0;
   int n_bad = 0;

   int t0 = 0;
   int wr_cnt, seq_bad, oob, zero_cnt, exp_addr;
   int first_busy, first_addr, last_wr, done_cyc, done_cnt, err_cnt;
   int err_at_done, busy_at_done, rom_at1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      wr_cnt = 0; seq_bad = 0; oob = 0; zero_cnt = 0; exp_addr = 0;
      first_busy = -1; first_addr = -1; last_wr = -1; done_cyc = -1;
      done_cnt = 0; err_cnt = 0; err_at_done = -1; busy_at_done = -1; rom_at1 = -1;
   endtask

   // Write/status monitor, sampled on the falling edge.
   always @(negedge Clk) begin
      if (Reset_n) begin
         if (pe_cnt - t0 == 1) rom_at1 = int'(bus.rom_addr);
         if (bus.busy && first_busy < 0) first_busy = pe_cnt - t0;
         if (bus.wr_en) begin
            if (first_addr < 0) first_addr = int'(bus.wr_addr);
            if (int'(bus.wr_addr) != exp_addr) seq_bad++;
            if (bus.wr_addr >= 9'd300) oob++;
            else mem[bus.wr_addr] = bus.wr_data;
            if (bus.wr_data == 4'd0) zero_cnt++;
            exp_addr++;
            wr_cnt++;
            last_wr = pe_cnt - t0;
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc = pe_cnt - t0;
            err_at_done = int'(bus.err);
            busy_at_done = int'(bus.busy);
         end
         if (bus.err) err_cnt++;
      end
   end

   task automatic start_load(input logic [1:0] lvl);
      @(negedge Clk);
      bus.load_req = 1'b1;
      bus.load_level = lvl;
      t0 = pe_cnt;
      @(negedge Clk);
      bus.load_req = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3000; i++) begin
         @(negedge Clk);
         #1;
         if (done_cnt > 0) break;
      end
      check_val("done_seen", 32'(done_cnt > 0), 32'd1);
   endtask

   int bad_cells;
   logic [9:0] rom_before;

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
      for (int i = 0; i < 300; i++) mem[i] = 4'hF;
      // level 0: 18 x 16 blocks + 12 blocks
      for (int i = 0; i < 18; i++) rom[i] = 8'h4F;
      rom[18] = 8'h4B;
      // level 1: block with dir, spike down, 18 x 16 blocks, 10 background
      rom[256] = 8'h50;
      rom[257] = 8'hB0;
      for (int i = 0; i < 18; i++) rom[258 + i] = 8'h4F;
      rom[276] = 8'h09;
      // level 2: 18 x 16 blocks then a 16-cell run with only 12 cells left
      for (int i = 0; i < 18; i++) rom[512 + i] = 8'h4F;
      rom[530] = 8'h2F;

      Reset_n = 1'b0;
      bus.load_req = 1'b0;
      bus.load_level = 2'b00;
      clear_mon();
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      #1;
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      check_val("rst_done", 32'(bus.done), 32'd0);
      check_val("rst_err", 32'(bus.err), 32'd0);
      check_val("rst_wr_en", 32'(bus.wr_en), 32'd0);
      check_val("rst_rom_addr", 32'(bus.rom_addr), 32'd0);

      // Full-block load
      clear_mon();
      start_load(2'b00);
      wait_done();
      repeat (3) @(negedge Clk);
      #1;
      check_val("full_wr_cnt", 32'(wr_cnt), 32'd300);
      check_val("full_seq", 32'(seq_bad), 32'd0);
      check_val("full_oob", 32'(oob), 32'd0);
      check_val("full_first_busy", 32'(first_busy), 32'd1);
      check_val("full_last_wr", 32'(last_wr), 32'd338);
      check_val("full_done_cyc", 32'(done_cyc), 32'd339);
      check_val("full_err", 32'(err_at_done), 32'd0);
      check_val("full_busy_done", 32'(busy_at_done), 32'd0);
      check_val("full_done_pulses", 32'(done_cnt), 32'd1);
      bad_cells = 0;
      for (int i = 0; i < 300; i++) if (mem[i] != 4'b0100) bad_cells++;
      check_val("full_cells", 32'(bad_cells), 32'd0);

      // Sanitising
      clear_mon();
      start_load(2'b01);
      wait_done();
      check_val("san_cell0", 32'(mem[0]), 32'b0100);
      check_val("san_cell1", 32'(mem[1]), 32'b1011);
      check_val("san_cell2", 32'(mem[2]), 32'b0100);
      check_val("san_cell299", 32'(mem[299]), 32'b0000);
      check_val("san_err", 32'(err_at_done), 32'd0);
      check_val("san_wr_cnt", 32'(wr_cnt), 32'd300);

      // Overrun
      clear_mon();
      start_load(2'b10);
      wait_done();
      repeat (2) @(negedge Clk);
      #1;
      check_val("ovr_wr_cnt", 32'(wr_cnt), 32'd300);
      check_val("ovr_zero_writes", 32'(zero_cnt), 32'd12);
      check_val("ovr_oob", 32'(oob), 32'd0);
      check_val("ovr_cell287", 32'(mem[287]), 32'b0100);
      check_val("ovr_cell288", 32'(mem[288]), 32'b0000);
      check_val("ovr_err_with_done", 32'(err_at_done), 32'd1);
      check_val("ovr_err_pulses", 32'(err_cnt), 32'd1);

      // Invalid level
      clear_mon();
      rom_before = bus.rom_addr;
      start_load(2'b11);
      repeat (5) @(negedge Clk);
      #1;
      check_val("inv_err_pulses", 32'(err_cnt), 32'd1);
      check_val("inv_wr_cnt", 32'(wr_cnt), 32'd0);
      check_val("inv_busy", 32'(first_busy), 32'hFFFF_FFFF);
      check_val("inv_done", 32'(done_cnt), 32'd0);
      check_val("inv_rom_addr", 32'(bus.rom_addr), 32'(rom_before));

      // Ignored request mid-RUN, then reset at cell 150
      clear_mon();
      start_load(2'b00);
      for (int i = 0; i < 1000; i++) begin
         @(negedge Clk);
         #1;
         if (wr_cnt >= 50) break;
      end
      bus.load_req = 1'b1;
      bus.load_level = 2'b01;
      @(negedge Clk);
      bus.load_req = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge Clk);
         #1;
         if (wr_cnt >= 150) break;
      end
      check_val("ign_seq", 32'(seq_bad), 32'd0);
      check_val("ign_wr_cnt", 32'(wr_cnt), 32'd150);
      #1;
      Reset_n = 1'b0;
      #1;
      check_val("arst_wr_en", 32'(bus.wr_en), 32'd0);
      check_val("arst_busy", 32'(bus.busy), 32'd0);
      check_val("arst_done", 32'(bus.done), 32'd0);
      check_val("arst_err", 32'(bus.err), 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      clear_mon();
      start_load(2'b01);
      wait_done();
      check_val("rst_load_first_addr", 32'(first_addr), 32'd0);
      check_val("rst_load_rom_addr", 32'(rom_at1), 32'd256);
      check_val("rst_load_wr_cnt", 32'(wr_cnt), 32'd300);
      check_val("rst_load_cell1", 32'(mem[1]), 32'b1011);

      // Request held high through DONE
      @(negedge Clk);
      clear_mon();
      bus.load_req = 1'b1;
      bus.load_level = 2'b00;
      t0 = pe_cnt;
      wait_done();
      check_val("hold_busy_done", 32'(bus.busy), 32'd0);
      @(negedge Clk);
      #1;
      check_val("hold_busy_idle", 32'(bus.busy), 32'd0);
      check_val("hold_wr_idle", 32'(bus.wr_en), 32'd0);
      @(posedge Clk);
      #1;
      bus.load_req = 1'b0;
      @(negedge Clk);
      #1;
      check_val("hold_busy_rise", 32'(bus.busy), 32'd1);
      clear_mon();
      wait_done();
      check_val("hold_second_err", 32'(err_at_done), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/map_loader.md
Name: map_loader

Overview:
- Writer side of the tile map. The display/collision path reads a 300-cell tile RAM (20x15 tiles of 32 px); this block fills that RAM when a level switch is requested.
- Fetches run-length-encoded level records from a synchronous level ROM, decodes them, and writes one cell per clock into the tile RAM write port.
- Reports busy, done and error status to the game-state logic, which drives the load request on map change (map0, map1, victory screen).

Parameters:
- ROM_AW, 10, level ROM address width.
- NUM_CELLS, 300, cells per level (20 columns x 15 rows).

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- load_req  in  1  load request; sampled only in IDLE.
- load_level  in  2  level to load: 00 map0, 01 map1, 10 victory, 11 invalid.
- rom_addr  out  ROM_AW  level ROM address.
- rom_data  in  8  ROM data, valid the cycle after rom_addr is presented.
- wr_en  out  1  tile RAM write strobe.
- wr_addr  out  9  cell index 0..299, equal to col + row*20.
- wr_data  out  4  {tile[1:0], spike_dir[1:0]}. Tile: 00 background, 01 block, 10 spike, 11 checkpoint. Spike_dir: 00 up, 01 right, 10 left, 11 down.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a load completes.
- err  out  1  one-cycle pulse on invalid level or run overrun.

Behaviour:
- Record byte format: [7:6] tile, [5:4] spike_dir, [3:0] run length minus 1, so each run is 1..16 cells.
- State machine states: IDLE, FETCH, LATCH, RUN, DONE.
- IDLE, load_req=1, load_level!=11: next state FETCH. rom_ptr <= LEVEL_BASE[load_level], cell_cnt <= 0.
- IDLE, load_req=1, load_level==11: err=1 for one cycle, stay IDLE, no writes.
- FETCH: rom_addr = rom_ptr. Next state LATCH.
- LATCH: capture rom_data into run_tile, run_dir and run_left (len-1). rom_ptr <= rom_ptr+1. Next state RUN.
- RUN: wr_en=1, wr_addr=cell_cnt, wr_data={run_tile, run_dir_sanitised}. cell_cnt increments every cycle.
  - Run ends when run_left==0: go to FETCH.
  - When cell_cnt==NUM_CELLS-1 is written: go to DONE regardless of run_left.
- Sanitise rule: spike_dir is written as 00 unless tile==10.
- Overrun: if a run still has cells left when cell 299 is written, truncate, set an overrun flag, and pulse err together with done.
- DONE: done=1, err=overrun flag, for exactly one cycle, then IDLE.
- busy=1 in FETCH, LATCH and RUN. busy=0 in IDLE and DONE.
- Per-record cost is 2+len cycles, with no prefetch.
- load_req is ignored outside IDLE, including during DONE.
- rom_addr holds rom_ptr in all states.
- wr_en, wr_addr, wr_data, busy, done and err decode from registered state only, with no combinational path from inputs.
- Reset (Reset_n low, asynchronous, any state including mid-RUN):
  - State IDLE; cell_cnt, rom_ptr, run registers and overrun flag cleared.
  - All outputs 0 immediately.
  - Tile RAM contents are undefined; the next load rewrites all 300 cells starting at address 0.
- Counter widths: cell_cnt 9 bits and never exceeds 299; rom_ptr ROM_AW bits and wraps modulo 2^ROM_AW.

Decomposition:
- Shared package map_pkg holds:
  - tile_t enum (TILE_BG, TILE_BLOCK, TILE_SPIKE, TILE_CHECK).
  - spike_dir_t enum (DIR_UP, DIR_RIGHT, DIR_LEFT, DIR_DOWN).
  - NUM_CELLS=300, MAP_COLS=20, MAP_ROWS=15.
  - LEVEL_BASE[0:3] ROM base address table.
  - loader state enum.
- Record decoding is inline. The tile RAM (map_tile_ram, 300x4, 1W/1R) and the level ROM are separate instances outside this block.

Test Plan:
- Full-block load: LEVEL_BASE[0]=0, ROM holds 18 x 8'h4F then 8'h4B, load_req at cycle 0 with level 00.
  -> wr_en for cells 0..299, all wr_data=4'b0100.
  -> FETCH at cycle 1, last write at cycle 338, done and busy=0 at cycle 339, err=0.
- Sanitising: records 8'h50 then 8'hB0.
  -> cell0 written 4'b0100 (dir dropped on a block).
  -> cell1 written 4'b1011 (spike, down).
- Overrun: 18 x 8'h4F then 8'h2F (16 cells) with 12 cells remaining.
  -> exactly 12 writes of 4'b0000, no write past 299, done and err both pulse at the same cycle.
- Invalid level: load_req with load_level=2'b11.
  -> err pulses for one cycle; wr_en, busy and done stay 0; rom_addr unchanged.
- Ignored request and reset:
  - Second load_req with level 01 mid-RUN -> ignored; addresses continue sequentially.
  - Reset_n low at cell 150 -> wr_en, busy, done and err go to 0 without waiting for a clock.
  - New load_req after reset -> writes restart at wr_addr 0 from LEVEL_BASE[level].
- Request during DONE: load_req held high through DONE.
  -> no second load starts in the DONE cycle; the request is accepted in the following IDLE cycle, with busy rising one cycle later.
